wb_dsp_equation_sequencer: RTL

Sequencer between the DSP slave register file and the Wishbone master interface. On a start request it issues single Wishbone transfers through the master interface: it fetches a 3-word equation descriptor, reads two operands, evaluates the selected equation, and writes the result back. It reports busy, done, error and abort status for the status register.

---
 rtl/wb_dsp_equation_sequencer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/wb_dsp_equation_sequencer.sv
// Equation sequencer: fetches a 3-word descriptor and two operands over the
// Wishbone master interface, evaluates ADD/SUB/MUL/AND and writes the result back.
module wb_dsp_equation_sequencer #(
   parameter int dw      = 32,
   parameter int aw      = 32,
   parameter int TIMEOUT = 256
) (
   input  logic          wb_clk,
   input  logic          wb_rst,
   input  logic          start_equation,
   input  logic          stop_equation,
   input  logic [7:0]    equation,
   input  logic [aw-1:0] equation_address,
   output logic          start,
   output logic [aw-1:0] address,
   output logic [3:0]    selection,
   output logic          write,
   output logic [dw-1:0] data_wr,
   input  logic [dw-1:0] data_rd,
   input  logic          active,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic          aborted,
   output logic [dw-1:0] result
);

   localparam int CW = $clog2(TIMEOUT) + 1;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EXEC, FINISH} state_t;

   state_t        state, state_next;
   logic          start_q;
   logic [2:0]    step;
   logic [7:0]    eq_reg;
   logic [aw-1:0] desc_addr, src_a_addr, src_b_addr, dst_addr;
   logic [dw-1:0] op_a, op_b;
   logic          seen;
   logic [CW-1:0] act_cnt;
   logic [2:0]    idle_cnt;

   logic          start_edge;
   logic          accept, do_issue, complete, step_inc, do_exec;
   logic          set_error, set_aborted, set_done;
   logic [aw-1:0] issue_addr;
   logic [dw-1:0] calc;

   assign selection  = 4'hF;
   assign busy       = (state != IDLE);
   assign start_edge = start_equation & ~start_q;

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next  = state;
      accept      = 1'b0;
      do_issue    = 1'b0;
      complete    = 1'b0;
      step_inc    = 1'b0;
      do_exec     = 1'b0;
      set_error   = 1'b0;
      set_aborted = 1'b0;
      set_done    = 1'b0;
      case (state)
         IDLE: begin
            if (start_edge && !stop_equation) begin
               accept = 1'b1;
               if (equation > 8'd3) set_error  = 1'b1;
               else                 state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (stop_equation) begin
               set_aborted = 1'b1;
               state_next  = IDLE;
            end else begin
               do_issue   = 1'b1;
               state_next = WAIT;
            end
         end
         WAIT: begin
            // Completion is the first low sample of active after a high one;
            // the two counters bound the pre-active and active phases.
            if (active) begin
               if (act_cnt == CW'(TIMEOUT - 1)) begin
                  set_error  = 1'b1;
                  state_next = IDLE;
               end
            end else if (seen) begin
               complete = 1'b1;
               if (stop_equation) begin
                  set_aborted = 1'b1;
                  state_next  = IDLE;
               end else if (step == 3'd4) begin
                  state_next = EXEC;
               end else if (step == 3'd5) begin
                  state_next = FINISH;
               end else begin
                  step_inc   = 1'b1;
                  state_next = ISSUE;
               end
            end else if (idle_cnt == 3'd3) begin
               set_error  = 1'b1;
               state_next = IDLE;
            end
         end
         EXEC: begin
            if (stop_equation) begin
               set_aborted = 1'b1;
               state_next  = IDLE;
            end else begin
               do_exec    = 1'b1;
               state_next = ISSUE;
            end
         end
         FINISH: begin
            set_done   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      case (step)
         3'd0:    issue_addr = desc_addr;
         3'd1:    issue_addr = desc_addr + aw'(4);
         3'd2:    issue_addr = desc_addr + aw'(8);
         3'd3:    issue_addr = src_a_addr;
         3'd4:    issue_addr = src_b_addr;
         default: issue_addr = dst_addr;
      endcase
   end

   always_comb begin
      case (eq_reg)
         8'd0:    calc = op_a + op_b;
         8'd1:    calc = op_a - op_b;
         8'd2:    calc = op_a * op_b;
         default: calc = op_a & op_b;
      endcase
   end

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         start_q    <= 1'b0;
         start      <= 1'b0;
         address    <= '0;
         write      <= 1'b0;
         data_wr    <= '0;
         done       <= 1'b0;
         error      <= 1'b0;
         aborted    <= 1'b0;
         result     <= '0;
         step       <= '0;
         eq_reg     <= '0;
         desc_addr  <= '0;
         src_a_addr <= '0;
         src_b_addr <= '0;
         dst_addr   <= '0;
         op_a       <= '0;
         op_b       <= '0;
         seen       <= 1'b0;
         act_cnt    <= '0;
         idle_cnt   <= '0;
      end else begin
         start_q <= start_equation;
         start   <= do_issue;

         if (do_issue) begin
            address  <= issue_addr;
            write    <= (step == 3'd5);
            data_wr  <= (step == 3'd5) ? result : '0;
            seen     <= 1'b0;
            act_cnt  <= '0;
            idle_cnt <= '0;
         end else if (state == WAIT) begin
            if (active) begin
               seen    <= 1'b1;
               act_cnt <= act_cnt + 1'b1;
            end else if (!seen) begin
               idle_cnt <= idle_cnt + 1'b1;
            end
         end

         if (complete) begin
            case (step)
               3'd0:    src_a_addr <= aw'(data_rd);
               3'd1:    src_b_addr <= aw'(data_rd);
               3'd2:    dst_addr   <= aw'(data_rd);
               3'd3:    op_a       <= data_rd;
               3'd4:    op_b       <= data_rd;
               default: ;
            endcase
         end

         if (step_inc) step <= step + 3'd1;

         if (do_exec) begin
            result <= calc;
            step   <= 3'd5;
         end

         // Clearing on accept precedes the sets so an unsupported op still flags error.
         if (accept) begin
            eq_reg    <= equation;
            desc_addr <= equation_address;
            done      <= 1'b0;
            error     <= 1'b0;
            aborted   <= 1'b0;
            step      <= '0;
         end
         if (set_error)   error   <= 1'b1;
         if (set_aborted) aborted <= 1'b1;
         if (set_done)    done    <= 1'b1;
      end
   end

endmodule
